// File: rtl/bus_req_router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : bus_req_router_pkg
// Description : Shared state encodings and counter width for the request
//               router and its address matcher.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package bus_req_router_pkg;

    // Width of the ACCESS-phase timeout counter
    localparam int c_cnt_w = 8;

    // Router FSM state encodings
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/bus_addr_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : bus_addr_match
// Description : Combinational address-window compare. Window i matches when
//               (addr & mask_i) == base_i; the lowest matching index wins.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module bus_addr_match #(
    parameter int                             NR_OF_BUSSES_OUT = 4,
    parameter int                             IDX_W            = 2,
    parameter logic [NR_OF_BUSSES_OUT*32-1:0] REGION_BASE      = '0,
    parameter logic [NR_OF_BUSSES_OUT*32-1:0] REGION_MASK      = '0
) (
    input  logic [31:0]      i_addr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    logic [NR_OF_BUSSES_OUT-1:0] w_match;

    generate
        for (genvar i = 0; i < NR_OF_BUSSES_OUT; i++) begin : g_cmp
            assign w_match[i] =
                ((i_addr & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]);
        end
    endgenerate

    // Priority encode: scan downwards so the lowest matching window is kept
    always_comb begin
        o_hit = |w_match;
        o_idx = '0;
        for (int i = NR_OF_BUSSES_OUT - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_req_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : bus_req_router
// Description : Routes a core load/store to one of NR_OF_BUSSES_OUT slave
//               windows, holds a one-hot strobe until the slave acks or the
//               access times out, then returns a one-cycle ready/err pulse
//               and registered read data.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module bus_req_router #(
    parameter int                             NR_OF_BUSSES_OUT = 4,
    parameter logic [NR_OF_BUSSES_OUT*32-1:0] REGION_BASE      = '0,
    parameter logic [NR_OF_BUSSES_OUT*32-1:0] REGION_MASK      = '0,
    parameter int                             TIMEOUT_CYCLES   = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      core_addr,
    input  logic [31:0]                      core_wdata,
    input  logic [3:0]                       core_be,
    input  logic                             core_rd,
    input  logic                             core_wr,
    output logic [31:0]                      core_rdata,
    output logic                             core_ready,
    output logic                             core_err,
    output logic [31:0]                      bus_addr,
    output logic [31:0]                      bus_wdata,
    output logic [3:0]                       bus_be,
    output logic [NR_OF_BUSSES_OUT-1:0]      bus_rd,
    output logic [NR_OF_BUSSES_OUT-1:0]      bus_wr,
    input  logic [NR_OF_BUSSES_OUT-1:0]      bus_ack,
    input  logic [NR_OF_BUSSES_OUT*32-1:0]   bus_rdata
);

    import bus_req_router_pkg::*;

    localparam int                 c_idx_w    = (NR_OF_BUSSES_OUT > 1) ? $clog2(NR_OF_BUSSES_OUT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_idx_w-1:0] r_sel;
    logic               r_is_rd;
    logic               r_err;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;
    logic [31:0]        r_rdata;

    logic               w_hit;
    logic [c_idx_w-1:0] w_idx;
    logic               w_req_any;
    logic               w_req_ok;
    logic               w_sel_ack;
    logic               w_timeout;
    logic [31:0]        w_slave_rdata [NR_OF_BUSSES_OUT];

    bus_addr_match #(
        .NR_OF_BUSSES_OUT (NR_OF_BUSSES_OUT),
        .IDX_W            (c_idx_w),
        .REGION_BASE      (REGION_BASE),
        .REGION_MASK      (REGION_MASK)
    ) u_match (
        .i_addr (core_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    generate
        for (genvar i = 0; i < NR_OF_BUSSES_OUT; i++) begin : g_unpack
            assign w_slave_rdata[i] = bus_rdata[i*32 +: 32];
        end
    endgenerate

    // A request is only forwarded when exactly one of rd/wr is set and a window hits
    assign w_req_any = core_rd | core_wr;
    assign w_req_ok  = (core_rd ^ core_wr) & w_hit;
    // Acks from slaves other than the selected one never influence the FSM
    assign w_sel_ack = bus_ack[r_sel];
    assign w_timeout = (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; ack takes precedence over a simultaneous timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req_any) begin
                    w_state_nxt = w_req_ok ? c_st_access : c_st_done;
                end
            end
            c_st_access: begin
                if (w_sel_ack || w_timeout) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ACCESS-phase cycle counter, cleared whenever not accessing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (r_state == c_st_access) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request capture in IDLE and completion status / read data in ACCESS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel   <= '0;
            r_is_rd <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_req_ok) begin
                        r_sel   <= w_idx;
                        r_is_rd <= core_rd;
                        r_addr  <= core_addr;
                        r_wdata <= core_wdata;
                        r_be    <= core_be;
                    end
                    if (w_req_any) begin
                        r_err <= ~w_req_ok;
                    end
                end
                c_st_access: begin
                    if (w_sel_ack) begin
                        r_err <= 1'b0;
                        if (r_is_rd) begin
                            r_rdata <= w_slave_rdata[r_sel];
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_err <= r_err;
                end
            endcase
        end
    end

    // Output decode from the registered state: strobes vanish as soon as reset hits
    always_comb begin
        bus_rd     = '0;
        bus_wr     = '0;
        core_ready = 1'b0;
        core_err   = 1'b0;
        case (r_state)
            c_st_access: begin
                if (r_is_rd) begin
                    bus_rd[r_sel] = 1'b1;
                end else begin
                    bus_wr[r_sel] = 1'b1;
                end
            end
            c_st_done: begin
                core_ready = 1'b1;
                core_err   = r_err;
            end
            default: begin
                core_ready = 1'b0;
            end
        endcase
    end

    assign bus_addr   = r_addr;
    assign bus_wdata  = r_wdata;
    assign bus_be     = r_be;
    assign core_rdata = r_rdata;

endmodule
`default_nettype wire
